uart_mem_initiator: RTL and testbench
=====================================

Name: uart_mem_initiator

Overview:
- CPU-side end of the UART memory link. Converts single CPU memory accesses into request messages on channel 0 of the multichannel UART comm block, and returns read data from the response.
- The remote memory-model responder decodes these messages and returns 4-byte read data.
- Sits between the CPU memory port and the multchan_comm channel-0 send/receive interface.

Parameters:
- ADDR_W, 32, CPU address width; zero-extended into the 32-bit address field.
- MSG_W, 72, message payload width; fixed to the channel message width.
- TIMEOUT_CYCLES, 1000000, read-response timeout; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mem_req  in  1  access request, sampled in IDLE
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  ADDR_W  byte address
- mem_wdata  in  32  write data
- mem_mask  in  4  byte-enable mask, bit i selects byte i
- mem_busy  out  1  request in flight
- mem_done  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, valid when mem_done is high and held until the next done
- mem_err  out  1  one-cycle pulse coincident with mem_done on a bad response or timeout
- send_flag  out  1  push message to the comm block
- send_length  out  5  message byte count
- send_data  out  MSG_W  message payload
- sendable  in  1  comm block can accept a message
- recv_flag  out  1  pop received message
- recv_length  in  5  received byte count
- recv_data  in  MSG_W  received payload
- recvable  in  1  received message available

Behaviour:
- All outputs are registered.
- Reset is synchronous and active-high, on rst at posedge clk:
  - state returns to IDLE;
  - mem_busy, mem_done, mem_err, send_flag and recv_flag go to 0;
  - mem_rdata, send_data and send_length go to 0;
  - any in-flight request is dropped with no done pulse.
- Read message:
  - length 5;
  - send_data[31:0] = addr, send_data[32] = 0, all other bits 0.
- Write message:
  - length 9;
  - send_data[31:0] = wdata, [63:32] = addr, [67:64] = mask, [71:68] = 0.
- Write has no response. A read response is length 4, with data in recv_data[31:0].
- FSM states: IDLE, SEND, WAIT_RESP.
- IDLE:
  - mem_req = 1 → latch we/addr/wdata/mask, set mem_busy = 1, go to SEND.
  - mem_req = 0 → mem_busy = 0.
- SEND:
  - Stay in SEND while sendable = 0; send_flag stays 0.
  - sendable = 1 → send_flag = 1 for exactly one cycle, with send_data/send_length driven that same cycle.
  - Write: mem_done = 1 in that same cycle, mem_busy returns to 0, go to IDLE.
  - Read: go to WAIT_RESP.
- WAIT_RESP, when recvable = 1 and recv_flag was 0 the previous cycle:
  - recv_flag = 1 for one cycle;
  - mem_rdata ← recv_data[31:0];
  - mem_done = 1; mem_busy returns to 0; go to IDLE.
  - recv_length ≠ 4 → also pulse mem_err; mem_rdata still takes recv_data[31:0].
- recv_flag is never high on two consecutive cycles, so a stale recvable cannot cause a double pop.
- Stray message in IDLE: recvable = 1 pops it and discards it, with no done or err pulse.
  - A simultaneous mem_req is still accepted in the same cycle.
- Latency with sendable = 1:
  - mem_req sampled at edge N;
  - send_flag high in the cycle after edge N+1;
  - a write's mem_done appears in that same cycle.
  - Read latency is unbounded: done follows the pop.
- mem_req is ignored while mem_busy = 1. The CPU holds request fields only until the accept edge.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined:
  - a counter clears on entry to WAIT_RESP and increments each WAIT_RESP cycle;
  - on reaching TIMEOUT_CYCLES-1: mem_done = 1, mem_err = 1, mem_rdata = 32'h0, go to IDLE;
  - a response arriving later is handled as a stray in IDLE.
- When not defined: no counter logic exists and WAIT_RESP waits indefinitely.

Test Plan:
- Read: addr 0x00000010, sendable = 1 → one send_flag pulse, length 5, send_data = 72'h00_00000010. Responder returns length 4 with 0xDEADBEEF → recv_flag pulse, mem_done pulse, mem_rdata = 0xDEADBEEF, mem_err = 0.
- Write: addr 0x104, wdata 0x11223344, mask 4'b0101 → length 9, send_data = 72'h5_00000104_11223344, mem_done in the same cycle as send_flag, recv_flag never asserted.
- Backpressure: sendable held 0 for 20 cycles → no send_flag and mem_busy = 1 throughout; sendable = 1 → a single send_flag on the next cycle.
- Stray: recvable = 1 in IDLE together with mem_req → stray popped with no done, request accepted; recvable held high for 3 cycles → recv_flag alternates and never has two consecutive highs.
- Bad length: read response with recv_length = 3 → mem_done and mem_err pulse together.
- Reset mid-read in WAIT_RESP → next cycle state is IDLE, all flags 0; a subsequent write completes normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 50, read with no response → done and err pulse 50 cycles after entering WAIT_RESP, mem_rdata = 0.

Source files
------------

// File: rtl/uart_mem_initiator.sv
// CPU memory port to UART comm channel-0 request/response bridge.
// Optional read-response timeout enabled by defining MEM_TIMEOUT_EN.
module uart_mem_initiator #(
  parameter int ADDR_W         = 32,
  parameter int MSG_W          = 72,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_mask,
  output logic              mem_busy,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              mem_err,
  output logic              send_flag,
  output logic [4:0]        send_length,
  output logic [MSG_W-1:0]  send_data,
  input  logic              sendable,
  output logic              recv_flag,
  input  logic [4:0]        recv_length,
  input  logic [MSG_W-1:0]  recv_data,
  input  logic              recvable
);

  if (TIMEOUT_CYCLES < 1) begin : g_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RESP
  } state_t;

  state_t state, state_n;

  logic              we_q, we_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [31:0]       wdata_q, wdata_n;
  logic [3:0]        mask_q, mask_n;

  logic              busy_n, done_n, err_n;
  logic [31:0]       rdata_n;
  logic              sflag_n, rflag_n;
  logic [4:0]        slen_n;
  logic [MSG_W-1:0]  sdata_n;

  logic [31:0]       addr32;
  logic              pop_ok;
  logic              unused_recv;

  assign addr32      = 32'(addr_q);
  assign pop_ok      = recvable && !recv_flag;
  assign unused_recv = ^recv_data[MSG_W-1:32];

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt, cnt_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      mem_busy    <= 1'b0;
      mem_done    <= 1'b0;
      mem_err     <= 1'b0;
      mem_rdata   <= '0;
      send_flag   <= 1'b0;
      send_length <= '0;
      send_data   <= '0;
      recv_flag   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      state       <= state_n;
      we_q        <= we_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      mask_q      <= mask_n;
      mem_busy    <= busy_n;
      mem_done    <= done_n;
      mem_err     <= err_n;
      mem_rdata   <= rdata_n;
      send_flag   <= sflag_n;
      send_length <= slen_n;
      send_data   <= sdata_n;
      recv_flag   <= rflag_n;
`ifdef MEM_TIMEOUT_EN
      cnt         <= cnt_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    we_n    = we_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    mask_n  = mask_q;
    busy_n  = mem_busy;
    done_n  = 1'b0;
    err_n   = 1'b0;
    rdata_n = mem_rdata;
    sflag_n = 1'b0;
    slen_n  = send_length;
    sdata_n = send_data;
    rflag_n = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_n   = cnt;
`endif
    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        // stray responses are popped and dropped
        if (pop_ok) rflag_n = 1'b1;
        if (mem_req) begin
          we_n    = mem_we;
          addr_n  = mem_addr;
          wdata_n = mem_wdata;
          mask_n  = mem_mask;
          busy_n  = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        if (sendable) begin
          sflag_n = 1'b1;
          if (we_q) begin
            slen_n  = 5'd9;
            sdata_n = MSG_W'({4'h0, mask_q, addr32, wdata_q});
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            slen_n  = 5'd5;
            sdata_n = MSG_W'(addr32);
            state_n = WAIT_RESP;
`ifdef MEM_TIMEOUT_EN
            cnt_n   = '0;
`endif
          end
        end
      end
      WAIT_RESP: begin
        if (pop_ok) begin
          rflag_n = 1'b1;
          rdata_n = recv_data[31:0];
          done_n  = 1'b1;
          err_n   = (recv_length != 5'd4);
          busy_n  = 1'b0;
          state_n = IDLE;
`ifdef MEM_TIMEOUT_EN
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          rdata_n = '0;
          done_n  = 1'b1;
          err_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_mem_initiator.sv
// Directed self-checking bench for uart_mem_initiator.
// Covers read, write, backpressure, strays, bad length, reset, timeout.
module tb_uart_mem_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_busy, mem_done, mem_err;
  logic [31:0] mem_rdata;
  logic        send_flag, recv_flag;
  logic [4:0]  send_length, recv_length;
  logic [71:0] send_data, recv_data;
  logic        sendable, recvable;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_mem_initiator #(
    .ADDR_W(32),
    .MSG_W(72),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_mask(mem_mask),
    .mem_busy(mem_busy),
    .mem_done(mem_done),
    .mem_rdata(mem_rdata),
    .mem_err(mem_err),
    .send_flag(send_flag),
    .send_length(send_length),
    .send_data(send_data),
    .sendable(sendable),
    .recv_flag(recv_flag),
    .recv_length(recv_length),
    .recv_data(recv_data),
    .recvable(recvable)
  );

  task automatic check(input string tag,
                       input logic [71:0] got,
                       input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = a;
    mem_wdata = d;
    mem_mask  = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic sf_seen, busy_low, rf_seen;
    int   k;
    rst = 1'b1; mem_req = 0; mem_we = 0; mem_addr = 0;
    mem_wdata = 0; mem_mask = 0; sendable = 0; recvable = 0;
    recv_length = 0; recv_data = 0;
    step(); step();
    rst = 1'b0;
    check("rst_busy", mem_busy, 0);
    check("rst_done", mem_done, 0);
    check("rst_sflag", send_flag, 0);
    check("rst_rflag", recv_flag, 0);
    check("rst_sdata", send_data, 0);
    check("rst_slen", send_length, 0);

    // read 0x10
    sendable = 1;
    req(0, 32'h10, 32'h0, 4'h0);
    step();
    mem_req = 0;
    check("rd_busy", mem_busy, 1);
    check("rd_sflag0", send_flag, 0);
    step();
    check("rd_sflag", send_flag, 1);
    check("rd_slen", send_length, 5);
    check("rd_sdata", send_data, 72'h00_00000010);
    check("rd_done0", mem_done, 0);
    step();
    check("rd_sflag_once", send_flag, 0);
    recvable = 1; recv_length = 4;
    recv_data = 72'hAB_00FF00FF_DEADBEEF;
    step();
    check("rd_rflag", recv_flag, 1);
    check("rd_done", mem_done, 1);
    check("rd_rdata", mem_rdata, 32'hDEADBEEF);
    check("rd_err", mem_err, 0);
    check("rd_busy_clr", mem_busy, 0);
    recvable = 0;
    step();
    check("rd_done_pulse", mem_done, 0);
    check("rd_rdata_hold", mem_rdata, 32'hDEADBEEF);

    // write 0x104
    req(1, 32'h104, 32'h11223344, 4'b0101);
    step();
    mem_req = 0;
    check("wr_busy", mem_busy, 1);
    step();
    check("wr_sflag", send_flag, 1);
    check("wr_slen", send_length, 9);
    check("wr_sdata", send_data, 72'h5_00000104_11223344);
    check("wr_done", mem_done, 1);
    check("wr_busy_clr", mem_busy, 0);
    check("wr_rflag", recv_flag, 0);
    step();
    check("wr_sflag_once", send_flag, 0);
    check("wr_done_pulse", mem_done, 0);
    check("wr_rflag2", recv_flag, 0);

    // backpressure
    sendable = 0;
    req(1, 32'h20, 32'hCAFEF00D, 4'hF);
    step();
    mem_req = 0;
    sf_seen = 0; busy_low = 0;
    for (int i = 0; i < 20; i++) begin
      sf_seen  = sf_seen | send_flag;
      busy_low = busy_low | !mem_busy;
      step();
    end
    check("bp_no_send", sf_seen, 0);
    check("bp_busy_low", busy_low, 0);
    sendable = 1;
    step();
    check("bp_sflag", send_flag, 1);
    check("bp_done", mem_done, 1);
    check("bp_sdata", send_data, 72'hF_00000020_CAFEF00D);
    step();
    check("bp_sflag_once", send_flag, 0);

    // stray in IDLE together with a read request
    sendable = 0;
    recvable = 1; recv_length = 4; recv_data = 72'h55;
    req(0, 32'h30, 32'h0, 4'h0);
    step();
    mem_req = 0; recvable = 0;
    check("st_rflag", recv_flag, 1);
    check("st_done", mem_done, 0);
    check("st_busy", mem_busy, 1);
    sendable = 1;
    step();
    check("st_sflag", send_flag, 1);
    check("st_sdata", send_data, 72'h30);
    step();
    // bad length response
    recvable = 1; recv_length = 3; recv_data = 72'h12345678;
    step();
    check("bl_done", mem_done, 1);
    check("bl_err", mem_err, 1);
    check("bl_rdata", mem_rdata, 32'h12345678);
    check("bl_rflag", recv_flag, 1);
    recvable = 0;
    step();
    check("bl_err_pulse", mem_err, 0);

    // recvable held 3 cycles in IDLE
    recvable = 1; recv_length = 4; recv_data = 72'h99;
    rf_seen = 0;
    step();
    check("alt_rf0", recv_flag, 1);
    rf_seen = rf_seen | mem_done;
    step();
    check("alt_rf1", recv_flag, 0);
    rf_seen = rf_seen | mem_done;
    step();
    check("alt_rf2", recv_flag, 1);
    rf_seen = rf_seen | mem_done;
    recvable = 0;
    step();
    check("alt_rf3", recv_flag, 0);
    check("alt_no_done", rf_seen, 0);

    // reset in WAIT_RESP
    req(0, 32'h40, 32'h0, 4'h0);
    step();
    mem_req = 0;
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    check("mr_busy", mem_busy, 0);
    check("mr_sflag", send_flag, 0);
    check("mr_rflag", recv_flag, 0);
    check("mr_done", mem_done, 0);
    check("mr_rdata", mem_rdata, 0);
    check("mr_sdata", send_data, 0);
    req(1, 32'h8, 32'hA5A5A5A5, 4'h3);
    step();
    mem_req = 0;
    step();
    check("mr_wr_sflag", send_flag, 1);
    check("mr_wr_done", mem_done, 1);
    check("mr_wr_sdata", send_data, 72'h3_00000008_A5A5A5A5);
    step();

`ifdef MEM_TIMEOUT_EN
    req(0, 32'h50, 32'h0, 4'h0);
    step();
    mem_req = 0;
    step();
    check("to_sflag", send_flag, 1);
    k = 0;
    while (!mem_done && k < 200) begin
      step();
      k++;
    end
    check("to_cycles", k, 50);
    check("to_err", mem_err, 1);
    check("to_rdata", mem_rdata, 0);
    step();
`else
    k = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
